// File: rtl/cheri_pkg.sv
// rtl/cheri_pkg.sv - shared TSMAP geometry and writer state encoding
package cheri_pkg;

   localparam int unsigned TSMAP_GRAN_LOG2 = 3;
   localparam int unsigned TSMAP_WORD_LOG2 = 5;

   typedef enum logic [1:0] {
      TSW_IDLE,
      TSW_CHECK,
      TSW_WRITE,
      TSW_DONE
   } tsmap_wr_state_e;

endpackage

// File: rtl/cheri_tsmap_mask_gen.sv
// rtl/cheri_tsmap_mask_gen.sv - contiguous bit mask covering [lo..hi] of one map word
module cheri_tsmap_mask_gen
   import cheri_pkg::*;
(
   input  logic [TSMAP_WORD_LOG2-1:0]      lo,
   input  logic [TSMAP_WORD_LOG2-1:0]      hi,
   output logic [(1<<TSMAP_WORD_LOG2)-1:0] mask
);

   always_comb begin
      mask = '0;
      for (int i = 0; i < (1 << TSMAP_WORD_LOG2); i++) begin
         mask[i] = (TSMAP_WORD_LOG2'(i) >= lo) && (TSMAP_WORD_LOG2'(i) <= hi);
      end
   end

endmodule

// File: rtl/cheri_tsmap_writer.sv
// rtl/cheri_tsmap_writer.sv - range set/clear engine issuing masked TSMAP word writes
module cheri_tsmap_writer
   import cheri_pkg::*;
#(
   parameter logic [31:0] HeapBase  = 32'h8000_0000,
   parameter int unsigned TSMapSize = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_start_i,
   input  logic [31:0] req_end_i,
   input  logic        req_set_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        tsmap_cs_o,
   output logic        tsmap_we_o,
   output logic [15:0] tsmap_addr_o,
   output logic [31:0] tsmap_wdata_o,
   output logic [31:0] tsmap_bwe_o,
   input  logic        tsmap_gnt_i
);

   localparam int unsigned WordShift = TSMAP_GRAN_LOG2 + TSMAP_WORD_LOG2;

   tsmap_wr_state_e state_q;
   logic [31:0]     start_q, end_q;
   logic            set_q;
   logic [31:0]     cur_word_q, last_word_q;
   logic [4:0]      last_bit_q;

   logic [31:0] off_s, off_e, gran_e, last_idx;
   logic [31:0] first_word_c, last_word_c, next_word_c;
   logic [4:0]  first_bit_c, last_bit_c;
   logic        range_err_c;
   logic [4:0]  mask_lo, mask_hi;
   logic [31:0] mask;

   // Offsets are taken relative to the heap base, so alignment is checked on them too.
   always_comb begin
      off_s        = start_q - HeapBase;
      off_e        = end_q - HeapBase;
      gran_e       = off_e >> TSMAP_GRAN_LOG2;
      last_idx     = gran_e - 32'd1;
      first_word_c = off_s >> WordShift;
      first_bit_c  = off_s[WordShift-1:TSMAP_GRAN_LOG2];
      last_word_c  = last_idx >> TSMAP_WORD_LOG2;
      last_bit_c   = last_idx[TSMAP_WORD_LOG2-1:0];
      next_word_c  = cur_word_q + 32'd1;
      range_err_c  = (start_q < HeapBase)
                  || (off_s[TSMAP_GRAN_LOG2-1:0] != '0)
                  || (off_e[TSMAP_GRAN_LOG2-1:0] != '0)
                  || (end_q <= start_q)
                  || (last_word_c >= TSMapSize);
   end

   // The mask is prepared one step ahead: for the first word in CHECK, for the next word in WRITE.
   always_comb begin
      mask_lo = '0;
      mask_hi = '1;
      if (state_q == TSW_CHECK) begin
         mask_lo = first_bit_c;
         mask_hi = (first_word_c == last_word_c) ? last_bit_c : 5'd31;
      end else begin
         mask_hi = (next_word_c == last_word_q) ? last_bit_q : 5'd31;
      end
   end

   cheri_tsmap_mask_gen u_mask_gen (
      .lo   (mask_lo),
      .hi   (mask_hi),
      .mask (mask)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= TSW_IDLE;
         start_q       <= '0;
         end_q         <= '0;
         set_q         <= 1'b0;
         cur_word_q    <= '0;
         last_word_q   <= '0;
         last_bit_q    <= '0;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
         tsmap_cs_o    <= 1'b0;
         tsmap_we_o    <= 1'b0;
         tsmap_addr_o  <= '0;
         tsmap_wdata_o <= '0;
         tsmap_bwe_o   <= '0;
      end else begin
         case (state_q)
            TSW_IDLE: begin
               if (req_valid_i) begin
                  start_q <= req_start_i;
                  end_q   <= req_end_i;
                  set_q   <= req_set_i;
                  state_q <= TSW_CHECK;
               end
            end
            TSW_CHECK: begin
               if (range_err_c) begin
                  done_o  <= 1'b1;
                  err_o   <= 1'b1;
                  state_q <= TSW_DONE;
               end else begin
                  cur_word_q    <= first_word_c;
                  last_word_q   <= last_word_c;
                  last_bit_q    <= last_bit_c;
                  tsmap_cs_o    <= 1'b1;
                  tsmap_we_o    <= 1'b1;
                  tsmap_addr_o  <= first_word_c[15:0];
                  tsmap_wdata_o <= {32{set_q}};
                  tsmap_bwe_o   <= mask;
                  state_q       <= TSW_WRITE;
               end
            end
            TSW_WRITE: begin
               // Without a grant every map output simply holds.
               if (tsmap_gnt_i) begin
                  if (cur_word_q == last_word_q) begin
                     tsmap_cs_o    <= 1'b0;
                     tsmap_we_o    <= 1'b0;
                     tsmap_addr_o  <= '0;
                     tsmap_wdata_o <= '0;
                     tsmap_bwe_o   <= '0;
                     done_o        <= 1'b1;
                     err_o         <= 1'b0;
                     state_q       <= TSW_DONE;
                  end else begin
                     cur_word_q   <= next_word_c;
                     tsmap_addr_o <= next_word_c[15:0];
                     tsmap_bwe_o  <= mask;
                  end
               end
            end
            TSW_DONE: begin
               done_o  <= 1'b0;
               err_o   <= 1'b0;
               state_q <= TSW_IDLE;
            end
            default: state_q <= TSW_IDLE;
         endcase
      end
   end

   assign req_ready_o = (state_q == TSW_IDLE);
   assign busy_o      = (state_q != TSW_IDLE);

endmodule

// File: tb/tb_cheri_tsmap_writer.sv
// tb/tb_cheri_tsmap_writer.sv - scoreboard bench for the TSMAP range writer
module tb_cheri_tsmap_writer;

   localparam logic [31:0] HB = 32'h8000_0000;
   localparam longint MAP_GRANS = 1024 * 32;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic [31:0] req_start_i = '0;
   logic [31:0] req_end_i = '0;
   logic        req_set_i = 1'b0;
   logic        tsmap_gnt_i = 1'b0;
   logic        req_ready_o, busy_o, done_o, err_o;
   logic        tsmap_cs_o, tsmap_we_o;
   logic [15:0] tsmap_addr_o;
   logic [31:0] tsmap_wdata_o, tsmap_bwe_o;

   cheri_tsmap_writer dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_start_i   (req_start_i),
      .req_end_i     (req_end_i),
      .req_set_i     (req_set_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .tsmap_cs_o    (tsmap_cs_o),
      .tsmap_we_o    (tsmap_we_o),
      .tsmap_addr_o  (tsmap_addr_o),
      .tsmap_wdata_o (tsmap_wdata_o),
      .tsmap_bwe_o   (tsmap_bwe_o),
      .tsmap_gnt_i   (tsmap_gnt_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] bwe;
      logic [31:0] wdata;
   } wr_t;

   wr_t         exp_wr[$];
   bit          exp_err[$];
   int          n_vec = 0;
   int          n_fail = 0;
   int unsigned cyc = 0;
   bit          in_flight = 0;
   int unsigned acc_cyc = 0, cs_cnt = 0, last_lat = 0;
   int          done_cnt = 0;
   int          gnt_mode = 0;
   int          stall_cnt = 0;
   logic [15:0] stall_addr = '0;
   logic        prev_cs = 0, prev_gnt = 0;
   logic [15:0] prev_addr = '0;
   logic [31:0] prev_bwe = '0, prev_wdata = '0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm, input string detail);
      n_vec++;
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", nm, detail, cyc);
   endtask

   always @(posedge clk_i) begin
      #1;
      case (gnt_mode)
         0: tsmap_gnt_i = 1'b1;
         1: tsmap_gnt_i = ($urandom_range(0, 3) != 0);
         default: begin
            if (tsmap_cs_o && tsmap_addr_o == stall_addr && stall_cnt < 3) begin
               tsmap_gnt_i = 1'b0;
               stall_cnt++;
            end else begin
               tsmap_gnt_i = 1'b1;
            end
         end
      endcase
   end

   always @(negedge clk_i) begin : monitor
      wr_t w;
      bit  e;
      if (rst_ni) begin
         chk("busy", busy_o, in_flight);
         chk("ready", req_ready_o, !in_flight);
         chk("we_eq_cs", tsmap_we_o, tsmap_cs_o);
         if (tsmap_cs_o) begin
            cs_cnt++;
            if (!in_flight || cyc < acc_cyc + 2)
               fail_now("cs_timing", $sformatf("got cs=1 addr %0h, expected cs=0", tsmap_addr_o));
            if (prev_cs && !prev_gnt) begin
               chk("hold_addr", tsmap_addr_o, prev_addr);
               chk("hold_bwe", tsmap_bwe_o, prev_bwe);
               chk("hold_wdata", tsmap_wdata_o, prev_wdata);
            end
            if (tsmap_gnt_i) begin
               if (exp_wr.size() == 0) begin
                  fail_now("wr_unexpected", $sformatf("got write addr %0h bwe %0h, expected none", tsmap_addr_o, tsmap_bwe_o));
               end else begin
                  w = exp_wr.pop_front();
                  chk("wr_addr", tsmap_addr_o, w.addr);
                  chk("wr_bwe", tsmap_bwe_o, w.bwe);
                  chk("wr_wdata", tsmap_wdata_o, w.wdata);
               end
            end
         end
         if (done_o) begin
            if (exp_err.size() == 0 || !in_flight) begin
               fail_now("done_unexpected", "got done_o=1, expected 0");
            end else begin
               e = exp_err.pop_front();
               chk("err", err_o, e);
               chk("done_latency", cyc - acc_cyc, 2 + cs_cnt);
               chk("writes_left", exp_wr.size(), 0);
               last_lat = cyc - acc_cyc;
            end
            in_flight = 0;
            done_cnt++;
         end else begin
            chk("err_idle", err_o, 0);
         end
         if (req_valid_i && req_ready_o) begin
            in_flight = 1;
            acc_cyc   = cyc;
            cs_cnt    = 0;
         end
         prev_cs    = tsmap_cs_o;
         prev_gnt   = tsmap_gnt_i;
         prev_addr  = tsmap_addr_o;
         prev_bwe   = tsmap_bwe_o;
         prev_wdata = tsmap_wdata_o;
      end
   end

   // Reference model: walk every granule of the range and gather per-word masks.
   task automatic issue(input logic [31:0] s, input logic [31:0] e, input logic set);
      bit     err;
      longint gs, ge;
      int     t;
      wr_t    x;
      err = (s < HB) || (s % 8 != 0) || (e % 8 != 0) || (e <= s);
      gs = 0;
      ge = 0;
      if (!err) begin
         gs = (longint'(s) - longint'(HB)) / 8;
         ge = (longint'(e) - longint'(HB)) / 8;
         if (ge > MAP_GRANS) err = 1;
      end
      exp_err.push_back(err);
      if (!err) begin
         for (longint wd = gs / 32; wd <= (ge - 1) / 32; wd++) begin
            x.addr  = wd[15:0];
            x.bwe   = '0;
            x.wdata = set ? 32'hFFFF_FFFF : 32'h0;
            for (int b = 0; b < 32; b++)
               if (wd * 32 + b >= gs && wd * 32 + b < ge) x.bwe[b] = 1'b1;
            exp_wr.push_back(x);
         end
      end
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b1;
      req_start_i = s;
      req_end_i   = e;
      req_set_i   = set;
      t = 0;
      @(negedge clk_i);
      while (!req_ready_o && t < 200) begin
         @(negedge clk_i);
         t++;
      end
      if (!req_ready_o) fail_now("accept_timeout", "got req_ready_o=0 for 200 cycles, expected 1");
      // A request presented while busy must be ignored.
      @(posedge clk_i);
      #1;
      req_start_i = $urandom;
      req_end_i   = $urandom;
      req_set_i   = ~set;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
   endtask

   task automatic wait_done();
      int d0;
      int t;
      d0 = done_cnt;
      t = 0;
      while (done_cnt == d0 && t < 2000) begin
         @(negedge clk_i);
         t++;
      end
      if (done_cnt == d0) fail_now("done_timeout", "got no done_o in 2000 cycles, expected one");
      repeat (2) @(posedge clk_i);
   endtask

   initial begin
      int          kind;
      longint      gs, ge;
      logic [31:0] s, e;
      int          t;

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_ready", req_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_cs", tsmap_cs_o, 0);
      chk("rst_we", tsmap_we_o, 0);
      chk("rst_addr", tsmap_addr_o, 0);
      chk("rst_wdata", tsmap_wdata_o, 0);
      chk("rst_bwe", tsmap_bwe_o, 0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      gnt_mode = 0;
      issue(32'h8000_0000, 32'h8000_0100, 1'b1); wait_done(); chk("lat_one_word", last_lat, 3);
      issue(32'h8000_0018, 32'h8000_0130, 1'b1); wait_done(); chk("lat_two_word", last_lat, 4);
      issue(32'h8000_0208, 32'h8000_0210, 1'b0); wait_done(); chk("lat_clear", last_lat, 3);
      issue(32'h7FFF_FFF8, 32'h8000_0100, 1'b1); wait_done(); chk("lat_below", last_lat, 2);
      issue(32'h8000_0004, 32'h8000_0100, 1'b1); wait_done(); chk("lat_misalign", last_lat, 2);
      issue(32'h8000_0100, 32'h8000_0100, 1'b1); wait_done(); chk("lat_empty", last_lat, 2);
      issue(32'h8000_0000, 32'h8004_0008, 1'b1); wait_done(); chk("lat_overmap", last_lat, 2);
      issue(32'h8003_FFF8, 32'h8004_0000, 1'b1); wait_done(); chk("lat_last_gran", last_lat, 3);

      gnt_mode = 2;
      stall_addr = 16'd1;
      stall_cnt = 0;
      issue(32'h8000_0000, 32'h8000_0400, 1'b1); wait_done(); chk("lat_stall", last_lat, 9);

      gnt_mode = 0;
      issue(32'h8000_1000, 32'h8000_1400, 1'b1);
      t = 0;
      @(negedge clk_i);
      while (!(tsmap_cs_o && tsmap_addr_o == 16'd17) && t < 50) begin
         @(negedge clk_i);
         t++;
      end
      if (!(tsmap_cs_o && tsmap_addr_o == 16'd17))
         fail_now("reset_setup", "got no write to word 17, expected one");
      #1 rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      exp_wr.delete();
      exp_err.delete();
      in_flight = 0;
      prev_cs = 0;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("mid_rst_ready", req_ready_o, 1);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_cs", tsmap_cs_o, 0);
      chk("mid_rst_done", done_o, 0);
      issue(32'h8000_1000, 32'h8000_1100, 1'b0); wait_done(); chk("lat_after_rst", last_lat, 3);

      gnt_mode = 1;
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0: begin
               s = HB + 32'(8 * $urandom_range(0, 1000));
               e = s + 32'd64;
               if ($urandom_range(0, 1) != 0) s = s + 32'($urandom_range(1, 7));
               else e = e + 32'd4;
            end
            1: begin
               s = HB - 32'(8 * $urandom_range(1, 100));
               e = HB + 32'(8 * $urandom_range(0, 50));
            end
            2: begin
               s = HB + 32'(8 * $urandom_range(1, 1000));
               e = s - 32'(8 * $urandom_range(0, 5));
            end
            3: begin
               gs = MAP_GRANS - longint'($urandom_range(1, 40));
               ge = gs + longint'($urandom_range(41, 100));
               s = HB + 32'(gs * 8);
               e = HB + 32'(ge * 8);
            end
            4: begin
               gs = MAP_GRANS - longint'($urandom_range(1, 100));
               s = HB + 32'(gs * 8);
               e = HB + 32'(MAP_GRANS * 8);
            end
            default: begin
               gs = longint'($urandom_range(0, 32767 - 200));
               ge = gs + longint'($urandom_range(1, 150));
               s = HB + 32'(gs * 8);
               e = HB + 32'(ge * 8);
            end
         endcase
         issue(s, e, 1'($urandom_range(0, 1)));
         wait_done();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
